// File: rtl/aplic_rr_select_if.sv
// Request/capture bus for the round-robin selector: per-channel requests and
// data in, one-hot grant plus a valid/ready element channel out.
interface aplic_rr_select_if #(
  parameter int N     = 8,
  parameter int elemW = 8
);
  localparam int IW = $clog2(N);

  logic [N-1:0]     req;
  logic [elemW-1:0] A [N];
  logic [N-1:0]     grant;
  logic             outValid;
  logic             outReady;
  logic [IW-1:0]    outIndex;
  logic [elemW-1:0] outElem;

  modport master (
    output req, A, outReady,
    input  grant, outValid, outIndex, outElem
  );

  modport slave (
    input  req, A, outReady,
    output grant, outValid, outIndex, outElem
  );
endinterface

// File: rtl/aplic_rr_select.sv
// Round-robin (or fixed-priority) request selector with a one-deep output hold.
// Define APLIC_RR_SELECT_FAIR_EN for rotating priority; default is fixed priority.
module aplic_rr_select #(
  parameter int N     = 8,
  parameter int elemW = 8
) (
  input  logic              clock,
  input  logic              reset,
  aplic_rr_select_if.slave  bus
);
  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state, state_nx;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    sel;
  logic             found;
  logic             opp;
  logic [N-1:0]     hi_req;
  logic [IW-1:0]    out_idx;
  logic [elemW-1:0] out_elem;

  // Lowest request at or above ptr wins; otherwise wrap to lowest request overall.
  always_comb begin
    hi_req = '0;
    sel    = '0;
    for (int i = 0; i < N; i++)
      hi_req[i] = bus.req[i] && (i >= int'(ptr));
    for (int i = N - 1; i >= 0; i--)
      if (bus.req[i]) sel = IW'(i);
    for (int i = N - 1; i >= 0; i--)
      if (hi_req[i]) sel = IW'(i);
  end

  assign found = |bus.req;
  assign opp   = (state == IDLE) || bus.outReady;

  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;

  always_comb begin
    state_nx = state;
    if (opp) state_nx = found ? HOLD : IDLE;
  end

  // Grant is masked by reset so nothing is offered while the block is held off.
  always_comb begin
    bus.outValid = (state == HOLD);
    bus.grant    = '0;
    if (opp && found && !reset) bus.grant[sel] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      out_idx  <= '0;
      out_elem <= '0;
    end else if (opp) begin
      if (found) begin
        out_idx  <= sel;
        out_elem <= bus.A[sel];
      end else begin
        out_idx  <= '0;
        out_elem <= '0;
      end
    end

  assign bus.outIndex = out_idx;
  assign bus.outElem  = out_elem;

`ifdef APLIC_RR_SELECT_FAIR_EN
  always_ff @(posedge clock or posedge reset)
    if (reset)
      ptr <= '0;
    else if (opp && found)
      ptr <= (sel == IW'(N - 1)) ? '0 : sel + IW'(1);
`else
  assign ptr = '0;
`endif

endmodule

// File: doc/aplic_rr_select.md
APLIC_RR_SELECT -- requirements
Module: APLIC_rrSelect

Interface
REQ-001 SHALL have parameter N, default 8, number of request channels (legal range 2..1024, need not be a power of 2).
REQ-002 SHALL have parameter elemW, default 8, width of each channel's data element.
REQ-003 SHALL have one clock and one reset: the clock is `clock` and the reset is `reset`; reset is asynchronous and active-high.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req  input  N  per-channel request; bit n means channel n has an element to offer.
REQ-007 SHALL have port A  input  N x elemW  unpacked array of per-channel data elements, A[n] meaningful only while req[n]=1.
REQ-008 SHALL have port grant  output  N  one-hot or zero; grant[n]=1 in exactly the cycle channel n's element is captured.
REQ-009 SHALL have port outValid  output  1  captured element is presented.
REQ-010 SHALL have port outReady  input  1  consumer accepts the presented element.
REQ-011 SHALL have port outIndex  output  clog2(N)  channel index of the presented element.
REQ-012 SHALL have port outElem  output  elemW  captured data of the presented element.

Function
REQ-013 SHALL keep a pointer register ptr (clog2(N) bits, values 0..N-1) and a two-state FSM {IDLE, HOLD}.
REQ-014 SHALL select combinationally the first index i with req[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrapping modulo N, never past N-1).
REQ-015 SHALL define a capture opportunity as (state=IDLE) or (state=HOLD and outValid and outReady).
REQ-016 SHALL, at a capture opportunity with |req=1, assert grant for the selected index that cycle, and on the next edge load outIndex=selected index and outElem=A[selected], with state=HOLD.
REQ-017 SHALL, at a capture opportunity with req=0, assert no grant and go to (or stay in) IDLE on the next edge.
REQ-018 SHALL drive outValid=1 exactly when state=HOLD; latency from req in IDLE to outValid is one cycle.
REQ-019 SHALL hold outIndex and outElem stable while outValid=1 and outReady=0, regardless of changes on req or A.
REQ-020 SHALL sustain one element per cycle when outReady stays 1 and requests are present (handshake and new capture in the same cycle).
REQ-021 SHALL, for the selection made during a HOLD handshake cycle, use the updated pointer value (per REQ-023), not the old ptr.
REQ-022 SHALL assert grant only at a capture opportunity; never twice for one captured element.
REQ-023 SHALL, at each capture, update ptr to (captured index + 1), with N-1 wrapping to 0 (fair mode only; see REQ-028).
REQ-024 SHALL drive outElem and outIndex to 0 whenever state=IDLE.

Reset
REQ-025 SHALL, while reset=1, immediately force state=IDLE, ptr=0, outValid=0, outIndex=0, outElem=0, and grant=0, independent of clock.
REQ-026 SHALL, on reset asserted mid-HOLD, discard the held element without any grant or handshake.
REQ-027 SHALL first evaluate a capture opportunity on the first rising edge after reset deasserts.

Configuration
REQ-028 SHALL, with macro APLIC_RR_SELECT_FAIR_EN defined, implement round-robin selection per REQ-013/REQ-014/REQ-023.
REQ-029 SHALL, without APLIC_RR_SELECT_FAIR_EN, implement fixed priority: ptr is held constant at 0, so the lowest set req index always wins. All other behaviour is unchanged.

Verification
REQ-030 SHALL cover, N=8, this scenario: reset pulse mid-HOLD with outValid=1 -> outValid=0, outIndex=0, outElem=0 immediately, with no grant.
REQ-031 SHALL cover, N=8 with FAIR_EN, this scenario: req=0x24, A[2]=0x22, A[5]=0x55, outReady=1 -> grant=0x04 then 0x20; outIndex/outElem 2/0x22 then 5/0x55.
REQ-032 SHALL cover, FAIR_EN, this scenario: req=0xFF held, outReady=1 -> outIndex 0,1,...,7,0 on consecutive cycles, with grant following one-hot.
REQ-033 SHALL cover, FAIR_EN, this scenario: ptr=7 after capturing index 6, req=0x41 -> next capture is index 0, ptr=1.
REQ-034 SHALL cover, without FAIR_EN, this scenario: req=0xFF, outReady=1 -> outIndex=0 every cycle, grant=0x01 every cycle.
REQ-035 SHALL cover this scenario: outReady=0 for 5 cycles while A[3] changes 0x10->0x99 after capture -> outElem stays 0x10, and grant=0x08 occurs once only.
